// File: rtl/usertype.sv
// Shared command/state types and default DRAM timing values for the bank command scheduler.
`ifndef BA_BITS
`define BA_BITS 3
`endif

package usertype;

    typedef enum logic [1:0] {
        ACT = 2'd0,
        RD  = 2'd1,
        WR  = 2'd2,
        PRE = 2'd3
    } bank_cmd_t;

    typedef enum logic [1:0] {
        ARB,
        REF_DRAIN,
        REF_ISSUE,
        REF_WAIT
    } sched_state_t;

    localparam int DEFAULT_TRRD = 4;
    localparam int DEFAULT_TCCD = 4;
    localparam int DEFAULT_TRFC = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: grants the first eligible requester at or after ptr.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && eligible[(int'(ptr) + k) % N]) begin
                grant[(int'(ptr) + k) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Per-bank command scheduler: round-robin grant under tRRD/tCCD spacing, with refresh
// draining, REF issue and tRFC blackout.
`ifndef BA_BITS
`define BA_BITS 3
`endif

module bank_cmd_scheduler
    import usertype::*;
#(
    parameter int NUM_BANKS  = 8,
    parameter int CYCLE_TRRD = DEFAULT_TRRD,
    parameter int CYCLE_TCCD = DEFAULT_TCCD,
    parameter int CYCLE_TRFC = DEFAULT_TRFC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic      [NUM_BANKS-1:0]     req_valid,
    input  bank_cmd_t [NUM_BANKS-1:0]     req_cmd,
    input  logic      [NUM_BANKS-1:0]     bank_ready,
    output logic      [NUM_BANKS-1:0]     req_ready,
    input  logic                          refresh_req,
    output logic                          refresh_ack,
    output logic                          refresh_flag,
    output logic                          issue_valid,
    output bank_cmd_t                     issue_cmd,
    output logic      [`BA_BITS-1:0]      issue_bank,
    output logic                          issue_ref
);

    localparam int BW     = `BA_BITS;
    localparam int TRRD_W = $clog2(CYCLE_TRRD + 1);
    localparam int TCCD_W = $clog2(CYCLE_TCCD + 1);
    localparam int TRFC_W = $clog2(CYCLE_TRFC + 1);

    sched_state_t      state, next_state;
    logic [BW-1:0]     rr_ptr;
    logic [TRRD_W-1:0] trrd_cnt;
    logic [TCCD_W-1:0] tccd_cnt;
    logic [TRFC_W-1:0] rfc_cnt;

    logic [NUM_BANKS-1:0] eligible;
    logic [NUM_BANKS-1:0] grant;
    logic [BW-1:0]        grant_idx;
    bank_cmd_t            grant_cmd;
    logic                 arb_open;
    logic                 granted;

    // PRE only waits for the bank itself; ACT and RD/WR also respect the shared spacing timers.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            case (req_cmd[i])
                ACT:     eligible[i] = req_valid[i] & bank_ready[i] & (trrd_cnt == '0);
                RD, WR:  eligible[i] = req_valid[i] & bank_ready[i] & (tccd_cnt == '0);
                default: eligible[i] = req_valid[i] & bank_ready[i];
            endcase
        end
    end

    rr_arbiter #(
        .N  (NUM_BANKS),
        .PW (BW)
    ) u_rr_arbiter (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (grant)
    );

    // Grants are also held off while rst_n is low so every output reads 0 during reset.
    assign arb_open  = rst_n && (state == ARB) && !refresh_req;
    assign req_ready = arb_open ? grant : '0;
    assign granted   = |req_ready;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (grant[i]) grant_idx = BW'(i);
        end
    end

    assign grant_cmd = req_cmd[grant_idx];

    always_comb begin
        next_state   = state;
        refresh_flag = 1'b0;
        refresh_ack  = 1'b0;
        case (state)
            ARB: begin
                if (refresh_req) next_state = REF_DRAIN;
            end
            REF_DRAIN: begin
                refresh_flag = 1'b1;
                if (&bank_ready) next_state = REF_ISSUE;
            end
            REF_ISSUE: begin
                refresh_flag = 1'b1;
                refresh_ack  = 1'b1;
                next_state   = REF_WAIT;
            end
            REF_WAIT: begin
                if (rfc_cnt == '0) next_state = ARB;
            end
            default: next_state = ARB;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB;
            rr_ptr      <= '0;
            issue_valid <= 1'b0;
            issue_cmd   <= ACT;
            issue_bank  <= '0;
            issue_ref   <= 1'b0;
        end else begin
            state       <= next_state;
            issue_valid <= granted;
            issue_ref   <= (state == REF_ISSUE);
            if (granted) begin
                issue_cmd  <= grant_cmd;
                issue_bank <= grant_idx;
                rr_ptr     <= BW'((int'(grant_idx) + 1) % NUM_BANKS);
            end
        end
    end

    // Spacing timers reload on the matching grant and otherwise count down to 0 and stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trrd_cnt <= '0;
            tccd_cnt <= '0;
            rfc_cnt  <= '0;
        end else begin
            if (granted && grant_cmd == ACT) begin
                trrd_cnt <= TRRD_W'(CYCLE_TRRD - 1);
            end else if (trrd_cnt != '0) begin
                trrd_cnt <= trrd_cnt - TRRD_W'(1);
            end

            if (granted && (grant_cmd == RD || grant_cmd == WR)) begin
                tccd_cnt <= TCCD_W'(CYCLE_TCCD - 1);
            end else if (tccd_cnt != '0) begin
                tccd_cnt <= tccd_cnt - TCCD_W'(1);
            end

            if (state == REF_ISSUE) begin
                rfc_cnt <= TRFC_W'(CYCLE_TRFC - 1);
            end else if (state == REF_WAIT && rfc_cnt != '0) begin
                rfc_cnt <= rfc_cnt - TRFC_W'(1);
            end
        end
    end

endmodule
